// File: rtl/phy_rx_lanes.sv
// phy_rx_lanes: serial word aligner and lane deserializer.
// Define PHY_RX_IDLE_OUT_EN to drive idle_out as the registered "not locked" flag.
module phy_rx_lanes #(
   parameter int               WIDTH      = 8,
   parameter int               LANES      = 4,
   parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(8'hBC),
   parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(8'h7C),
   parameter int               SYNC_COUNT = 4
) (
   input  logic                   clk_32f,
   input  logic                   rst,
   input  logic                   data_in,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_valid,
   output logic                   frame_strobe,
   output logic                   active,
   output logic                   idle_out
);
   localparam int BW = $clog2(WIDTH);
   localparam int SW = LANES > 1 ? $clog2(LANES) : 1;
   typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;
   state_t                 r_state;
   logic [WIDTH-1:0]       r_sr, w_word;
   logic [BW-1:0]          r_bit;
   logic [3:0]             r_sync;
   logic [SW-1:0]          r_slot;
   logic [LANES*WIDTH-1:0] r_stage, w_stage;
   logic [LANES-1:0]       r_stv, w_stv;
   logic                   w_bnd, w_fill, w_last;
   assign w_word = {r_sr[WIDTH-2:0], data_in};
   assign w_bnd  = r_bit == BW'(WIDTH-1);
   assign w_fill = r_state == ACTIVE && w_bnd && w_word != SYNC_WORD;
   assign w_last = r_slot == SW'(LANES-1);
   // staging with the word completing this cycle merged in, so a full frame loads in one edge
   always_comb begin
      w_stage = r_stage;
      w_stv   = r_stv;
      if (w_fill) begin
         w_stage[r_slot*WIDTH +: WIDTH] = w_word == IDLE_WORD ? '0 : w_word;
         w_stv[r_slot]                  = w_word != IDLE_WORD;
      end
   end
   always_ff @(posedge clk_32f) begin
      if (rst) begin
         r_state      <= SEARCH;
         r_sr         <= '0;
         r_bit        <= '0;
         r_sync       <= '0;
         r_slot       <= '0;
         r_stage      <= '0;
         r_stv        <= '0;
         out_data     <= '0;
         out_valid    <= '0;
         frame_strobe <= 1'b0;
         active       <= 1'b0;
      end else begin
         r_sr         <= w_word;
         r_bit        <= (r_state == SEARCH || w_bnd) ? '0 : r_bit + 1'b1;
         frame_strobe <= 1'b0;
         active       <= r_state == ACTIVE;
         case (r_state)
            SEARCH: if (w_word == SYNC_WORD) begin
               r_sync  <= 4'd1;
               r_state <= SYNC_COUNT == 1 ? ACTIVE : SYNC;
               r_slot  <= '0;
               r_stage <= '0;
               r_stv   <= '0;
            end
            SYNC: if (w_bnd) begin
               if (w_word == SYNC_WORD) begin
                  r_sync <= r_sync + 1'b1;
                  if (r_sync + 1'b1 == 4'(SYNC_COUNT)) r_state <= ACTIVE;
               end else begin
                  r_sync  <= '0;
                  r_state <= SEARCH;
               end
            end
            default: if (w_fill) begin
               r_stage <= w_stage;
               r_stv   <= w_stv;
               r_slot  <= w_last ? '0 : r_slot + 1'b1;
               if (w_last) begin
                  out_data     <= w_stage;
                  out_valid    <= w_stv;
                  frame_strobe <= 1'b1;
               end
            end
         endcase
      end
   end
`ifdef PHY_RX_IDLE_OUT_EN
   always_ff @(posedge clk_32f) idle_out <= rst || r_state != ACTIVE;
`else
   always_ff @(posedge clk_32f) idle_out <= rst;
`endif
endmodule

// File: tb/tb_phy_rx_lanes.sv
// tb_phy_rx_lanes: randomized and directed checks of phy_rx_lanes against a word-level model.
module tb_phy_rx_lanes;
`ifdef PHY_RX_IDLE_OUT_EN
   localparam bit IDLE_EN = 1'b1;
`else
   localparam bit IDLE_EN = 1'b0;
`endif
   logic        clk = 0, rst = 1, din = 0, rst1 = 1, din1 = 0;
   logic [31:0] od;
   logic [3:0]  ov;
   logic        fs, act, idl;
   logic [19:0] od1;
   logic [1:0]  ov1;
   logic        fs1, act1, idl1;
   int          checks = 0, errors = 0, nstb = 0, nstb1 = 0, s;
   always #5 clk = ~clk;
   phy_rx_lanes u0 (.clk_32f(clk), .rst(rst), .data_in(din), .out_data(od), .out_valid(ov),
                    .frame_strobe(fs), .active(act), .idle_out(idl));
   phy_rx_lanes #(.WIDTH(10), .LANES(2), .SYNC_COUNT(2), .SYNC_WORD(10'h17C)) u1 (
      .clk_32f(clk), .rst(rst1), .data_in(din1), .out_data(od1), .out_valid(ov1),
      .frame_strobe(fs1), .active(act1), .idle_out(idl1));
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   // model: mode 0 hunting, 1 counting syncs, 2 locked; words collected in queues
   int          m_win, m_mode, m_phase, m_nsync;
   logic [7:0]  qd[$], wb;
   logic        qv[$];
   logic [31:0] e_data;
   logic [3:0]  e_valid;
   logic        e_stb, e_act, e_idl;
   bit          mv = 0;
   always @(posedge clk) begin
      if (rst) begin
         m_win = 0; m_mode = 0; m_phase = 0; m_nsync = 0;
         qd.delete(); qv.delete();
         e_data = 0; e_valid = 0; e_stb = 0; e_act = 0; e_idl = 1; mv = 1;
      end else begin
         m_win = ((m_win << 1) | int'(din)) & 'hFF;
         wb = m_win[7:0];
         e_stb = 0;
         e_act = m_mode == 2;
         e_idl = IDLE_EN && m_mode != 2;
         if (m_mode == 0) begin
            if (wb == 8'hBC) begin m_mode = 1; m_phase = 0; m_nsync = 1; end
         end else begin
            m_phase = m_phase + 1;
            if (m_phase == 8) begin
               m_phase = 0;
               if (m_mode == 1) begin
                  if (wb == 8'hBC) begin
                     m_nsync = m_nsync + 1;
                     if (m_nsync == 4) begin m_mode = 2; qd.delete(); qv.delete(); end
                  end else m_mode = 0;
               end else if (wb != 8'hBC) begin
                  qd.push_back(wb == 8'h7C ? 8'h00 : wb);
                  qv.push_back(wb != 8'h7C);
                  if (qd.size() == 4) begin
                     for (int k = 0; k < 4; k++) begin
                        e_data[k*8 +: 8] = qd[k];
                        e_valid[k] = qv[k];
                     end
                     e_stb = 1;
                     qd.delete(); qv.delete();
                  end
               end
            end
         end
      end
   end
   always @(negedge clk) if (mv) begin
      chk("out_data", od, e_data);
      chk("out_valid", 32'(ov), 32'(e_valid));
      chk("frame_strobe", 32'(fs), 32'(e_stb));
      chk("active", 32'(act), 32'(e_act));
      chk("idle_out", 32'(idl), 32'(e_idl));
      if (fs) nstb++;
      if (fs1) nstb1++;
   end
   task automatic send(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) begin @(negedge clk); din = w[i]; end
   endtask
   task automatic send10(input logic [9:0] w);
      for (int i = 9; i >= 0; i--) begin @(negedge clk); din1 = w[i]; end
   endtask
   task automatic do_rst(input int n);
      @(negedge clk); rst = 1; din = 0;
      repeat (n) @(negedge clk);
      rst = 0;
   endtask
   task automatic settle;
      @(negedge clk); #1;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_data", od, 0);
      chk("rst_valid", 32'(ov), 0);
      chk("rst_active", 32'(act), 0);
      chk("rst_idle", 32'(idl), 1);
      rst = 0;
      s = nstb;
      repeat (4) send(8'hBC);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      settle;
      chk("f1_data", od, 32'h44332211);
      chk("f1_valid", 32'(ov), 32'hF);
      chk("f1_count", nstb - s, 1);
      chk("f1_active", 32'(act), 1);
      chk("f1_idle", 32'(idl), 0);
      do_rst(2);
      repeat (4) send(8'hBC);
      send(8'hAA); send(8'h7C); send(8'hBC); send(8'hBB); send(8'hCC);
      settle;
      chk("f2_data", od, 32'hCCBB00AA);
      chk("f2_valid", 32'(ov), 32'b1101);
      do_rst(2);
      repeat (3) send(8'hBC);
      #1 chk("s3_idle", 32'(idl), 32'(IDLE_EN));
      send(8'h55);
      settle; settle;
      chk("s3_noact", 32'(act), 0);
      repeat (4) send(8'hBC);
      settle;
      chk("s3_act_lag", 32'(act), 0);
      settle;
      chk("s3_act", 32'(act), 1);
      chk("s3_idle_lock", 32'(idl), 0);
      do_rst(2);
      s = nstb;
      repeat (4) send(8'hBC);
      send(8'h11); send(8'h22);
      do_rst(2);
      settle;
      chk("r4_data", od, 0);
      chk("r4_valid", 32'(ov), 0);
      chk("r4_active", 32'(act), 0);
      chk("r4_count", nstb - s, 0);
      send(8'h33); send(8'h44); send(8'h55); send(8'h66);
      repeat (3) send(8'hBC);
      #1 chk("r4_not_yet", 32'(act), 0);
      send(8'hBC);
      settle; settle;
      chk("r4_relock", 32'(act), 1);
      for (int t = 0; t < 5; t++) begin
         do_rst(2);
         repeat ($urandom_range(0, 15)) begin @(negedge clk); din = 1'($urandom_range(0, 1)); end
         repeat (4) send(8'hBC);
         for (int j = 0; j < 60; j++) begin
            logic [7:0] w;
            int r;
            r = $urandom_range(0, 7);
            w = r == 0 ? 8'hBC : r == 1 ? 8'h7C : 8'($urandom);
            send(w);
         end
      end
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         din = 1'($urandom_range(0, 1));
         rst = $urandom_range(0, 99) == 0;
      end
      rst = 0;
      s = nstb1;
      @(negedge clk); rst1 = 0;
      send10(10'h17C); send10(10'h17C); send10(10'h3FF);
      #1 chk("w10_hold", 32'(od1), 0);
      send10(10'h001);
      settle;
      chk("w10_data", 32'(od1), 32'h007FF);
      chk("w10_valid", 32'(ov1), 32'b11);
      chk("w10_strobe", 32'(fs1), 1);
      chk("w10_count", nstb1 - s, 1);
      chk("w10_active", 32'(act1), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
